deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer.sv | 81 ++++++++
 tb/tb_deserializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: collects MSB-first frames of up to DATA_BUS_WIDTH bits
// and presents each completed frame of three or more bits as a left-aligned word with a one-cycle strobe.
module deserializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o
);

    typedef enum logic {
        IDLE_S,
        RECV_S
    } state_t;

    // One extra bit so the counter can represent a full DATA_BUS_WIDTH-bit frame.
    localparam int CNT_W = DATA_MOD_WIDTH + 1;
    localparam logic [DATA_MOD_WIDTH-1:0] TOP_IDX  = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1);
    localparam logic [CNT_W-1:0]          FULL_CNT = CNT_W'(DATA_BUS_WIDTH);
    localparam logic [CNT_W-1:0]          MIN_CNT  = CNT_W'(3);

    state_t                    state;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_inc;
    logic [DATA_BUS_WIDTH-1:0] shift_buf;
    logic [DATA_BUS_WIDTH-1:0] next_buf;
    logic [DATA_MOD_WIDTH-1:0] bit_idx;

    // A zero count marks the first bit of a frame, so the buffer restarts from all zeros.
    // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        bit_idx           = TOP_IDX - count[DATA_MOD_WIDTH-1:0];
        count_inc         = count + CNT_W'(1);
        next_buf          = (count == '0) ? '0 : shift_buf;
        next_buf[bit_idx] = ser_data_i;
    end

    // NOTE: state registers use non-blocking assignments so every update reads pre-edge values.
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state            <= IDLE_S;
            count            <= '0;
            shift_buf        <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= 1'b0;
            if (ser_data_val_i) begin
                shift_buf <= next_buf;
                state     <= RECV_S;
                if (count_inc == FULL_CNT) begin
                    // Full end: stay in RECV_S with a zero count so a following valid bit opens a new frame.
                    deser_data_o     <= next_buf;
                    deser_data_mod_o <= count_inc[DATA_MOD_WIDTH-1:0];
                    deser_data_val_o <= 1'b1;
                    count            <= '0;
                end else begin
                    count <= count_inc;
                end
            end else begin
                if (state == RECV_S && count >= MIN_CNT) begin
                    deser_data_o     <= shift_buf;
                    deser_data_mod_o <= count[DATA_MOD_WIDTH-1:0];
                    deser_data_val_o <= 1'b1;
                end
                state <= IDLE_S;
                count <= '0;
            end
        end
    end

    assign busy_o = (state == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: a table of directed frames, hand-written corner
// sequences (back-to-back full frame, asynchronous reset mid-frame) and a random frame sweep.
module tb_deserializer;

    logic        clk_i = 1'b0;
    logic        srst_i = 1'b0;
    logic        ser_data_i = 1'b0;
    logic        ser_data_val_i = 1'b0;
    logic [15:0] deser_data_o;
    logic [3:0]  deser_data_mod_o;
    logic        deser_data_val_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    deserializer #(.DATA_BUS_WIDTH(16), .DATA_MOD_WIDTH(4)) dut (
        .clk_i            (clk_i),
        .srst_i           (srst_i),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] bits;
        int          len;
        int          gap;
        int          exp_strobes;
        logic [15:0] exp_data;
        logic [3:0]  exp_mod;
        int          exp_pos;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives len bits MSB-first with valid high, then gap cycles with valid low.
    // Samples 1 ns after each posedge and records strobes by posedge index (1-based).
    task automatic send(input logic [15:0] v, input int len, input int gap,
                        output int n_strobe, output int first_pos,
                        output logic [15:0] sd, output logic [3:0] sm, output logic busy_end);
        logic [15:0] sh;
        int pos;
        sh = v;
        pos = 0;
        n_strobe = 0;
        first_pos = -1;
        sd = '0;
        sm = '0;
        for (int i = 0; i < len + gap; i++) begin
            @(negedge clk_i);
            if (i < len) begin
                ser_data_val_i = 1'b1;
                ser_data_i     = sh[15];
                sh             = sh << 1;
            end else begin
                ser_data_val_i = 1'b0;
                ser_data_i     = 1'b0;
            end
            @(posedge clk_i);
            #1;
            pos++;
            if (deser_data_val_o) begin
                n_strobe++;
                if (first_pos < 0) begin
                    first_pos = pos;
                    sd = deser_data_o;
                    sm = deser_data_mod_o;
                end
            end
        end
        busy_end = busy_o;
    endtask

    vec_t        vecs[8];
    int          ns;
    int          fp;
    logic [15:0] sd;
    logic [3:0]  sm;
    logic        be;
    logic [15:0] ref_data;
    logic [3:0]  ref_mod;
    logic [15:0] rv;
    int          rlen;
    int          rgap;
    int          busy_low;
    string       tag;

    initial begin
        vecs[0] = '{16'hA5C3, 16, 2, 1, 16'hA5C3, 4'd0, 16};
        vecs[1] = '{16'hB000,  5, 1, 1, 16'hB000, 4'd5,  6};
        vecs[2] = '{16'hC000,  2, 2, 0, 16'hB000, 4'd5, -1};
        vecs[3] = '{16'h8000,  1, 1, 0, 16'hB000, 4'd5, -1};
        vecs[4] = '{16'hE000,  3, 1, 1, 16'hE000, 4'd3,  4};
        vecs[5] = '{16'h1235, 15, 1, 1, 16'h1234, 4'd15, 16};
        vecs[6] = '{16'hFFFF, 16, 1, 1, 16'hFFFF, 4'd0, 16};
        vecs[7] = '{16'h5A00,  8, 3, 1, 16'h5A00, 4'd8,  9};

        // Reset state, asserted between clock edges.
        #1 srst_i = 1'b1;
        #1;
        check("reset_data", 32'(deser_data_o), 32'h0);
        check("reset_mod", 32'(deser_data_mod_o), 32'h0);
        check("reset_val", 32'(deser_data_val_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        repeat (2) @(negedge clk_i);
        srst_i = 1'b0;

        foreach (vecs[k]) begin
            send(vecs[k].bits, vecs[k].len, vecs[k].gap, ns, fp, sd, sm, be);
            tag = $sformatf("vec%0d", k);
            check({tag, "_strobes"}, 32'(ns), 32'(vecs[k].exp_strobes));
            check({tag, "_pos"}, 32'(fp), 32'(vecs[k].exp_pos));
            if (vecs[k].exp_strobes != 0) begin
                check({tag, "_strobe_data"}, 32'(sd), 32'(vecs[k].exp_data));
                check({tag, "_strobe_mod"}, 32'(sm), 32'(vecs[k].exp_mod));
            end
            check({tag, "_hold_data"}, 32'(deser_data_o), 32'(vecs[k].exp_data));
            check({tag, "_hold_mod"}, 32'(deser_data_mod_o), 32'(vecs[k].exp_mod));
            check({tag, "_busy_end"}, 32'(be), 32'h0);
        end

        // Back-to-back: 16 ones immediately followed by 0,1,0, then one low cycle.
        busy_low = 0;
        ns = 0;
        rv = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            ser_data_val_i = (i < 19);
            ser_data_i     = (i < 16) ? 1'b1 : (i == 17);
            @(posedge clk_i);
            #1;
            if (i < 19 && !busy_o) busy_low++;
            if (deser_data_val_o) begin
                ns++;
                if (i == 15) begin
                    check("b2b_first_data", 32'(deser_data_o), 32'hFFFF);
                    check("b2b_first_mod", 32'(deser_data_mod_o), 32'h0);
                end else if (i == 19) begin
                    check("b2b_second_data", 32'(deser_data_o), 32'h4000);
                    check("b2b_second_mod", 32'(deser_data_mod_o), 32'h3);
                end else begin
                    check("b2b_strobe_cycle", 32'(i), 32'hFFFF_FFFF);
                end
            end
        end
        check("b2b_strobes", 32'(ns), 32'd2);
        check("b2b_busy_gaps", 32'(busy_low), 32'd0);
        check("b2b_busy_end", 32'(busy_o), 32'h0);

        // Asynchronous reset after 7 bits of a frame.
        ns = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            ser_data_val_i = 1'b1;
            ser_data_i     = 1'b1;
            @(posedge clk_i);
        end
        #2 srst_i = 1'b1;
        #1;
        check("midrst_data", 32'(deser_data_o), 32'h0);
        check("midrst_mod", 32'(deser_data_mod_o), 32'h0);
        check("midrst_busy", 32'(busy_o), 32'h0);
        @(negedge clk_i);
        ser_data_val_i = 1'b0;
        repeat (2) @(negedge clk_i);
        srst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            if (deser_data_val_o) ns++;
        end
        check("midrst_no_strobe", 32'(ns), 32'd0);
        send(16'hF000, 4, 1, ns, fp, sd, sm, be);
        check("postrst_strobes", 32'(ns), 32'd1);
        check("postrst_pos", 32'(fp), 32'd5);
        check("postrst_data", 32'(sd), 32'hF000);
        check("postrst_mod", 32'(sm), 32'h4);

        // Random frame lengths and gaps against a left-aligned masking model.
        ref_data = 16'hF000;
        ref_mod  = 4'h4;
        for (int r = 0; r < 40; r++) begin
            rv   = 16'($urandom);
            rlen = int'($urandom_range(16, 1));
            rgap = int'($urandom_range(3, 1));
            send(rv, rlen, rgap, ns, fp, sd, sm, be);
            tag = $sformatf("rnd%0d_len%0d", r, rlen);
            if (rlen >= 3) begin
                ref_data = rv & ~(16'hFFFF >> rlen);
                ref_mod  = 4'(rlen % 16);
                check({tag, "_strobes"}, 32'(ns), 32'd1);
                check({tag, "_pos"}, 32'(fp), 32'((rlen == 16) ? 16 : rlen + 1));
                check({tag, "_data"}, 32'(sd), 32'(ref_data));
                check({tag, "_mod"}, 32'(sm), 32'(ref_mod));
            end else begin
                check({tag, "_strobes"}, 32'(ns), 32'd0);
            end
            check({tag, "_hold_data"}, 32'(deser_data_o), 32'(ref_data));
            check({tag, "_hold_mod"}, 32'(deser_data_mod_o), 32'(ref_mod));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
